// File: rtl/obi_data_arbiter.sv
// obi_data_arbiter
//   Two-master (core, vlsu) OBI arbiter onto a single data-memory port.
//   Request selection is combinational. A stalled request (req without gnt)
//   locks the selection until it is granted. Each issued transfer records its
//   owner in a small routing FIFO so responses return to the right master
//   with zero latency. A response with no outstanding owner is dropped and
//   raises a sticky error flag.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> contention goes to the master not granted last
//                       undefined -> core always wins contention
//
// Parameters:
//   MAX_OUTSTANDING  depth of the response-routing FIFO (1..4)
//
// Ports:
//   clk, n_reset                         clock, async active-low reset
//   core_*/vlsu_* req/addr/we/be/wdata   per-master OBI request inputs
//   core_*/vlsu_* gnt/rvalid/rdata       per-master grant and response outputs
//   mem_req/addr/we/be/wdata_o           shared request to data memory
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i memory grant and response
//   resp_err_o                           sticky orphan-response flag
module obi_data_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic [31:0] core_addr_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  input  logic        vlsu_req_i,
  output logic        vlsu_gnt_o,
  input  logic [31:0] vlsu_addr_i,
  input  logic        vlsu_we_i,
  input  logic [3:0]  vlsu_be_i,
  input  logic [31:0] vlsu_wdata_i,
  output logic        vlsu_rvalid_o,
  output logic [31:0] vlsu_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        resp_err_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    M_CORE = 1'b0,
    M_VLSU = 1'b1
  } master_e;

  master_e         r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_lock;
  master_e         r_lock_sel;
  logic            r_err;
`ifdef ARB_ROUND_ROBIN_EN
  master_e         r_last;
`endif

  logic            w_full;
  logic            w_empty;
  logic            w_sel_valid;
  master_e         w_sel;
  logic            w_issue;
  logic            w_pop;
  master_e         w_head;

  assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rptr];

  // A full FIFO suppresses selection entirely, so a same-cycle pop cannot
  // let a new request through; the freed slot is usable next cycle.
  always_comb begin
    w_sel       = M_CORE;
    w_sel_valid = 1'b0;
    if (!w_full) begin
      if (r_lock) begin
        w_sel       = r_lock_sel;
        w_sel_valid = 1'b1;
      end else if (core_req_i && vlsu_req_i) begin
        w_sel_valid = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        w_sel       = (r_last == M_CORE) ? M_VLSU : M_CORE;
`else
        w_sel       = M_CORE;
`endif
      end else if (core_req_i) begin
        w_sel       = M_CORE;
        w_sel_valid = 1'b1;
      end else if (vlsu_req_i) begin
        w_sel       = M_VLSU;
        w_sel_valid = 1'b1;
      end
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (w_sel_valid) begin
      if (w_sel == M_CORE) begin
        mem_req_o   = core_req_i;
        mem_addr_o  = core_addr_i;
        mem_we_o    = core_we_i;
        mem_be_o    = core_be_i;
        mem_wdata_o = core_wdata_i;
      end else begin
        mem_req_o   = vlsu_req_i;
        mem_addr_o  = vlsu_addr_i;
        mem_we_o    = vlsu_we_i;
        mem_be_o    = vlsu_be_i;
        mem_wdata_o = vlsu_wdata_i;
      end
    end
  end

  assign w_issue    = mem_req_o & mem_gnt_i;
  assign core_gnt_o = w_issue & (w_sel == M_CORE);
  assign vlsu_gnt_o = w_issue & (w_sel == M_VLSU);

  assign w_pop         = mem_rvalid_i & ~w_empty;
  assign core_rvalid_o = w_pop & (w_head == M_CORE);
  assign vlsu_rvalid_o = w_pop & (w_head == M_VLSU);
  assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
  assign vlsu_rdata_o  = vlsu_rvalid_o ? mem_rdata_i : '0;
  assign resp_err_o    = r_err;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        r_fifo[i] <= M_CORE;
      end
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_lock     <= 1'b0;
      r_lock_sel <= M_CORE;
      r_err      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last     <= M_VLSU;
`endif
    end else begin
      r_lock     <= mem_req_o & ~mem_gnt_i;
      r_lock_sel <= w_sel;

      if (w_issue) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr <= (r_wptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wptr + 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        r_last <= w_sel;
`endif
      end

      if (w_pop) begin
        r_rptr <= (r_rptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rptr + 1'b1;
      end

      if (w_issue && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_issue && w_pop) begin
        r_count <= r_count - 1'b1;
      end

      if (mem_rvalid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_obi_data_arbiter.sv
module tb_obi_data_arbiter;

  logic        clk;
  logic        n_reset;
  logic        core_req_i, vlsu_req_i;
  logic        core_gnt_o, vlsu_gnt_o;
  logic [31:0] core_addr_i, vlsu_addr_i;
  logic        core_we_i, vlsu_we_i;
  logic [3:0]  core_be_i, vlsu_be_i;
  logic [31:0] core_wdata_i, vlsu_wdata_i;
  logic        core_rvalid_o, vlsu_rvalid_o;
  logic [31:0] core_rdata_o, vlsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        resp_err_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  obi_data_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .core_req_i   (core_req_i),
    .core_gnt_o   (core_gnt_o),
    .core_addr_i  (core_addr_i),
    .core_we_i    (core_we_i),
    .core_be_i    (core_be_i),
    .core_wdata_i (core_wdata_i),
    .core_rvalid_o(core_rvalid_o),
    .core_rdata_o (core_rdata_o),
    .vlsu_req_i   (vlsu_req_i),
    .vlsu_gnt_o   (vlsu_gnt_o),
    .vlsu_addr_i  (vlsu_addr_i),
    .vlsu_we_i    (vlsu_we_i),
    .vlsu_be_i    (vlsu_be_i),
    .vlsu_wdata_i (vlsu_wdata_i),
    .vlsu_rvalid_o(vlsu_rvalid_o),
    .vlsu_rdata_o (vlsu_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .resp_err_o   (resp_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected contention winners for four back-to-back granted cycles
  // (1 = vlsu, 0 = core). Round-robin starts at core because vlsu was the
  // last master granted before that sequence.
  logic win [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    win[0] = 1'b0; win[1] = 1'b1; win[2] = 1'b0; win[3] = 1'b1;
`else
    win[0] = 1'b0; win[1] = 1'b0; win[2] = 1'b0; win[3] = 1'b0;
`endif
    n_reset = 1'b0;
    core_req_i = 0; core_addr_i = '0; core_we_i = 0; core_be_i = '0; core_wdata_i = '0;
    vlsu_req_i = 0; vlsu_addr_i = '0; vlsu_we_i = 0; vlsu_be_i = '0; vlsu_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    cyc(); cyc();

    // Reset state
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_core_gnt", 32'(core_gnt_o), 32'd0);
    chk("rst_vlsu_gnt", 32'(vlsu_gnt_o), 32'd0);
    chk("rst_err", 32'(resp_err_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    n_reset = 1'b1;
    cyc();

    // Core alone reads 0x100, response next cycle
    core_req_i = 1; core_addr_i = 32'h100; core_be_i = 4'hF; mem_gnt_i = 1;
    #1;
    chk("rd_core_gnt", 32'(core_gnt_o), 32'd1);
    chk("rd_vlsu_gnt", 32'(vlsu_gnt_o), 32'd0);
    chk("rd_mem_addr", mem_addr_o, 32'h100);
    chk("rd_mem_be", 32'(mem_be_o), 32'hF);
    cyc();
    core_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("rd_core_rvalid", 32'(core_rvalid_o), 32'd1);
    chk("rd_core_rdata", core_rdata_o, 32'hDEADBEEF);
    chk("rd_vlsu_rvalid", 32'(vlsu_rvalid_o), 32'd0);
    chk("rd_vlsu_rdata", vlsu_rdata_o, 32'd0);
    chk("idle_mem_addr", mem_addr_o, 32'd0);
    cyc();
    mem_rvalid_i = 0;

    // Lock: vlsu stalled, core joins while gnt=0 for 3 cycles
    vlsu_req_i = 1; vlsu_addr_i = 32'h300;
    #1;
    chk("lk0_mem_req", 32'(mem_req_o), 32'd1);
    chk("lk0_mem_addr", mem_addr_o, 32'h300);
    chk("lk0_vlsu_gnt", 32'(vlsu_gnt_o), 32'd0);
    cyc();
    core_req_i = 1; core_addr_i = 32'h200;
    for (int i = 1; i < 3; i++) begin
      #1;
      chk("lk_mem_addr", mem_addr_o, 32'h300);
      chk("lk_core_gnt", 32'(core_gnt_o), 32'd0);
      cyc();
    end
    mem_gnt_i = 1;
    #1;
    chk("lk_rel_vlsu_gnt", 32'(vlsu_gnt_o), 32'd1);
    chk("lk_rel_core_gnt", 32'(core_gnt_o), 32'd0);
    chk("lk_rel_addr", mem_addr_o, 32'h300);
    cyc();
    core_req_i = 0; vlsu_req_i = 0; mem_gnt_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE0001;
    #1;
    chk("lk_vlsu_rvalid", 32'(vlsu_rvalid_o), 32'd1);
    chk("lk_vlsu_rdata", vlsu_rdata_o, 32'hCAFE0001);
    chk("lk_core_rvalid", 32'(core_rvalid_o), 32'd0);
    cyc();
    mem_rvalid_i = 0;

    // Continuous contention with push+pop each cycle after the first
    core_req_i = 1; core_addr_i = 32'h400;
    vlsu_req_i = 1; vlsu_addr_i = 32'h500;
    mem_gnt_i = 1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        mem_rvalid_i = 1; mem_rdata_i = 32'h1000 + 32'(k);
      end
      #1;
      chk("cont_core_gnt", 32'(core_gnt_o), 32'(!win[k]));
      chk("cont_vlsu_gnt", 32'(vlsu_gnt_o), 32'(win[k]));
      if (k > 0) begin
        chk("cont_core_rvalid", 32'(core_rvalid_o), 32'(!win[k-1]));
        chk("cont_vlsu_rvalid", 32'(vlsu_rvalid_o), 32'(win[k-1]));
      end
      cyc();
    end
    core_req_i = 0; vlsu_req_i = 0; mem_gnt_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'h2000;
    #1;
    chk("drain_vlsu_rvalid", 32'(vlsu_rvalid_o), 32'(win[3]));
    chk("drain_core_rvalid", 32'(core_rvalid_o), 32'(!win[3]));
    cyc();
    mem_rvalid_i = 0;

    // FIFO full: core read, vlsu write, then third request blocked
    core_req_i = 1; core_addr_i = 32'h600; mem_gnt_i = 1;
    #1;
    chk("f_core_gnt", 32'(core_gnt_o), 32'd1);
    cyc();
    core_req_i = 0;
    vlsu_req_i = 1; vlsu_addr_i = 32'h700; vlsu_we_i = 1; vlsu_be_i = 4'h3; vlsu_wdata_i = 32'h12345678;
    #1;
    chk("f_vlsu_gnt", 32'(vlsu_gnt_o), 32'd1);
    chk("f_mem_we", 32'(mem_we_o), 32'd1);
    chk("f_mem_be", 32'(mem_be_o), 32'h3);
    chk("f_mem_wdata", mem_wdata_o, 32'h12345678);
    cyc();
    vlsu_req_i = 0; vlsu_we_i = 0; vlsu_be_i = '0; vlsu_wdata_i = '0;
    core_req_i = 1; core_addr_i = 32'h800;
    #1;
    chk("full_mem_req", 32'(mem_req_o), 32'd0);
    chk("full_core_gnt", 32'(core_gnt_o), 32'd0);
    chk("full_mem_addr", mem_addr_o, 32'd0);
    cyc();
    mem_rvalid_i = 1; mem_rdata_i = 32'hA1;
    #1;
    chk("fullpop_mem_req", 32'(mem_req_o), 32'd0);
    chk("fullpop_core_gnt", 32'(core_gnt_o), 32'd0);
    chk("fullpop_core_rvalid", 32'(core_rvalid_o), 32'd1);
    chk("fullpop_core_rdata", core_rdata_o, 32'hA1);
    cyc();
    mem_rdata_i = 32'hB2;
    #1;
    chk("afterpop_mem_req", 32'(mem_req_o), 32'd1);
    chk("afterpop_core_gnt", 32'(core_gnt_o), 32'd1);
    chk("afterpop_vlsu_rvalid", 32'(vlsu_rvalid_o), 32'd1);
    chk("afterpop_vlsu_rdata", vlsu_rdata_o, 32'hB2);
    chk("afterpop_core_rvalid", 32'(core_rvalid_o), 32'd0);
    cyc();
    core_req_i = 0; mem_gnt_i = 0; mem_rdata_i = 32'hC3;
    #1;
    chk("last_core_rvalid", 32'(core_rvalid_o), 32'd1);
    chk("last_core_rdata", core_rdata_o, 32'hC3);
    cyc();
    mem_rvalid_i = 0;

    // Orphan response with empty FIFO
    chk("pre_err", 32'(resp_err_o), 32'd0);
    mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    #1;
    chk("orph_core_rvalid", 32'(core_rvalid_o), 32'd0);
    chk("orph_vlsu_rvalid", 32'(vlsu_rvalid_o), 32'd0);
    chk("orph_core_rdata", core_rdata_o, 32'd0);
    cyc();
    mem_rvalid_i = 0;
    chk("orph_err_set", 32'(resp_err_o), 32'd1);
    cyc(); cyc();
    chk("orph_err_sticky", 32'(resp_err_o), 32'd1);
    n_reset = 0;
    #1;
    chk("orph_err_reset", 32'(resp_err_o), 32'd0);
    cyc();
    n_reset = 1;
    cyc();

    // Reset discards an outstanding entry
    core_req_i = 1; core_addr_i = 32'h900; mem_gnt_i = 1;
    #1;
    chk("rstmid_core_gnt", 32'(core_gnt_o), 32'd1);
    cyc();
    core_req_i = 0; mem_gnt_i = 0;
    n_reset = 0;
    cyc();
    n_reset = 1;
    cyc();
    mem_rvalid_i = 1; mem_rdata_i = 32'h77;
    #1;
    chk("rstmid_core_rvalid", 32'(core_rvalid_o), 32'd0);
    chk("rstmid_vlsu_rvalid", 32'(vlsu_rvalid_o), 32'd0);
    cyc();
    mem_rvalid_i = 0;
    chk("rstmid_err", 32'(resp_err_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
